renkon_layer_sched: RTL and testbench

- Sequences multi-layer inference on the renkon controller/datapath.
- Host loads up to MAXLAYER layer descriptors into an internal table, then pulses start.
- Block presents each layer's configuration to renkon_ctrl, issues req, waits for ack, advances to the next layer, and reports done plus a cycle count.
- Sits between the host register interface and renkon_ctrl's req/ack and parameter inputs.

---
 rtl/renkon_layer_sched_if.sv | 52 +++++
 rtl/renkon_layer_sched.sv | 144 ++++++++++++++
 tb/tb_renkon_layer_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/renkon_layer_sched_if.sv
// Host configuration and renkon_ctrl handshake bundle for the multi-layer scheduler.
// The scheduler connects through the slave modport; the host/controller side uses master.
interface renkon_layer_sched_if #(
    parameter int LWIDTH   = 10,
    parameter int MEMSIZE  = 12,
    parameter int NETSIZE  = 11,
    parameter int MAXLAYER = 8,
    parameter int CWIDTH   = 16
);
    localparam int NLW  = $clog2(MAXLAYER + 1);
    localparam int IDXW = $clog2(MAXLAYER);

    logic               start;
    logic [NLW-1:0]     num_layers;
    logic               cfg_we;
    logic [IDXW-1:0]    cfg_layer;
    logic [4:0]         cfg_field;
    logic [CWIDTH-1:0]  cfg_wdata;
    logic               ack;

    logic               req;
    logic [LWIDTH-1:0]  qbits, total_out, total_in, img_height, img_width;
    logic [LWIDTH-1:0]  fea_height, fea_width, conv_kern, conv_strid, conv_pad;
    logic [LWIDTH-1:0]  pool_kern, pool_strid, pool_pad;
    logic               bias_en, relu_en, pool_en;
    logic [MEMSIZE-1:0] in_offset, out_offset;
    logic [NETSIZE-1:0] net_offset;
    logic               busy;
    logic               done;
    logic [IDXW-1:0]    layer_idx;
    logic [31:0]        cycle_cnt;
    logic               cfg_err;
    logic               proto_err;

    modport master (
        output start, num_layers, cfg_we, cfg_layer, cfg_field, cfg_wdata, ack,
        input  req, qbits, total_out, total_in, img_height, img_width,
               fea_height, fea_width, conv_kern, conv_strid, conv_pad,
               pool_kern, pool_strid, pool_pad, bias_en, relu_en, pool_en,
               in_offset, out_offset, net_offset, busy, done, layer_idx,
               cycle_cnt, cfg_err, proto_err
    );

    modport slave (
        input  start, num_layers, cfg_we, cfg_layer, cfg_field, cfg_wdata, ack,
        output req, qbits, total_out, total_in, img_height, img_width,
               fea_height, fea_width, conv_kern, conv_strid, conv_pad,
               pool_kern, pool_strid, pool_pad, bias_en, relu_en, pool_en,
               in_offset, out_offset, net_offset, busy, done, layer_idx,
               cycle_cnt, cfg_err, proto_err
    );
endinterface

// File: rtl/renkon_layer_sched.sv
// Multi-layer sequencer: holds a descriptor table written by the host and walks
// renkon_ctrl through layers 0..num_layers-1 with a req/ack handshake per layer.
module renkon_layer_sched #(
    parameter int LWIDTH   = 10,
    parameter int MEMSIZE  = 12,
    parameter int NETSIZE  = 11,
    parameter int MAXLAYER = 8,
    parameter int CWIDTH   = 16
) (
    input  logic                clk,
    input  logic                xrst,
    renkon_layer_sched_if.slave bus
);
    localparam int NLW  = $clog2(MAXLAYER + 1);
    localparam int IDXW = $clog2(MAXLAYER);

    typedef struct packed {
        logic [LWIDTH-1:0]  qbits, total_out, total_in, img_height, img_width;
        logic [LWIDTH-1:0]  fea_height, fea_width, conv_kern, conv_strid, conv_pad;
        logic [LWIDTH-1:0]  pool_kern, pool_strid, pool_pad;
        logic               bias_en, relu_en, pool_en;
        logic [MEMSIZE-1:0] in_offset, out_offset;
        logic [NETSIZE-1:0] net_offset;
    } desc_t;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, FIN} state_t;

    state_t          state, next_state;
    desc_t           tbl [MAXLAYER];
    desc_t           cur;
    logic [IDXW-1:0] layer_idx;
    logic [NLW-1:0]  nl_latched;
    logic [NLW-1:0]  nl_sat;
    logic [31:0]     cycle_cnt;
    logic            cfg_err, proto_err;
    logic            busy_st, start_ok, last_layer;
    logic            unused_wdata;

    assign busy_st    = (state == LOAD) || (state == REQ) || (state == WAIT);
    assign start_ok   = (state == IDLE) && bus.start;
    assign nl_sat     = (bus.num_layers > NLW'(MAXLAYER)) ? NLW'(MAXLAYER) : bus.num_layers;
    assign last_layer = (NLW'(layer_idx) == nl_latched - NLW'(1));
    assign unused_wdata = ^bus.cfg_wdata[CWIDTH-1:MEMSIZE];

    // Descriptor table has no reset so its contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && !busy_st) begin
            case (bus.cfg_field)
                5'd0:  tbl[bus.cfg_layer].qbits      <= bus.cfg_wdata[LWIDTH-1:0];
                5'd1:  tbl[bus.cfg_layer].total_out  <= bus.cfg_wdata[LWIDTH-1:0];
                5'd2:  tbl[bus.cfg_layer].total_in   <= bus.cfg_wdata[LWIDTH-1:0];
                5'd3:  tbl[bus.cfg_layer].img_height <= bus.cfg_wdata[LWIDTH-1:0];
                5'd4:  tbl[bus.cfg_layer].img_width  <= bus.cfg_wdata[LWIDTH-1:0];
                5'd5:  tbl[bus.cfg_layer].fea_height <= bus.cfg_wdata[LWIDTH-1:0];
                5'd6:  tbl[bus.cfg_layer].fea_width  <= bus.cfg_wdata[LWIDTH-1:0];
                5'd7:  tbl[bus.cfg_layer].conv_kern  <= bus.cfg_wdata[LWIDTH-1:0];
                5'd8:  tbl[bus.cfg_layer].conv_strid <= bus.cfg_wdata[LWIDTH-1:0];
                5'd9:  tbl[bus.cfg_layer].conv_pad   <= bus.cfg_wdata[LWIDTH-1:0];
                5'd10: tbl[bus.cfg_layer].pool_kern  <= bus.cfg_wdata[LWIDTH-1:0];
                5'd11: tbl[bus.cfg_layer].pool_strid <= bus.cfg_wdata[LWIDTH-1:0];
                5'd12: tbl[bus.cfg_layer].pool_pad   <= bus.cfg_wdata[LWIDTH-1:0];
                5'd13: begin
                    tbl[bus.cfg_layer].bias_en <= bus.cfg_wdata[0];
                    tbl[bus.cfg_layer].relu_en <= bus.cfg_wdata[1];
                    tbl[bus.cfg_layer].pool_en <= bus.cfg_wdata[2];
                end
                5'd14: tbl[bus.cfg_layer].in_offset  <= bus.cfg_wdata[MEMSIZE-1:0];
                5'd15: tbl[bus.cfg_layer].out_offset <= bus.cfg_wdata[MEMSIZE-1:0];
                5'd16: tbl[bus.cfg_layer].net_offset <= bus.cfg_wdata[NETSIZE-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start) next_state = (bus.num_layers == '0) ? FIN : LOAD;
            LOAD: next_state = REQ;
            REQ:  next_state = WAIT;
            WAIT: if (bus.ack) next_state = last_layer ? FIN : LOAD;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Error flags clear on an accepted start, but a same-cycle violation still sets them.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            cur        <= '0;
            layer_idx  <= '0;
            nl_latched <= '0;
            cycle_cnt  <= '0;
            cfg_err    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (start_ok) begin
                layer_idx  <= '0;
                nl_latched <= nl_sat;
                cycle_cnt  <= '0;
                cfg_err    <= 1'b0;
                proto_err  <= 1'b0;
            end else begin
                if (busy_st) cycle_cnt <= cycle_cnt + 32'd1;
                if ((state == WAIT) && bus.ack && !last_layer) layer_idx <= layer_idx + IDXW'(1);
            end
            if (state == LOAD) cur <= tbl[layer_idx];
            if (bus.cfg_we && busy_st) cfg_err <= 1'b1;
            if (bus.ack && (state != WAIT)) proto_err <= 1'b1;
        end
    end

    assign bus.req        = (state == REQ);
    assign bus.done       = (state == FIN);
    assign bus.busy       = busy_st;
    assign bus.layer_idx  = layer_idx;
    assign bus.cycle_cnt  = cycle_cnt;
    assign bus.cfg_err    = cfg_err;
    assign bus.proto_err  = proto_err;
    assign bus.qbits      = cur.qbits;
    assign bus.total_out  = cur.total_out;
    assign bus.total_in   = cur.total_in;
    assign bus.img_height = cur.img_height;
    assign bus.img_width  = cur.img_width;
    assign bus.fea_height = cur.fea_height;
    assign bus.fea_width  = cur.fea_width;
    assign bus.conv_kern  = cur.conv_kern;
    assign bus.conv_strid = cur.conv_strid;
    assign bus.conv_pad   = cur.conv_pad;
    assign bus.pool_kern  = cur.pool_kern;
    assign bus.pool_strid = cur.pool_strid;
    assign bus.pool_pad   = cur.pool_pad;
    assign bus.bias_en    = cur.bias_en;
    assign bus.relu_en    = cur.relu_en;
    assign bus.pool_en    = cur.pool_en;
    assign bus.in_offset  = cur.in_offset;
    assign bus.out_offset = cur.out_offset;
    assign bus.net_offset = cur.net_offset;
endmodule

// File: tb/tb_renkon_layer_sched.sv
// Randomized bench for renkon_layer_sched: a descriptor-table model plus closed-form
// timing (req i at 2+i*(d+2), done at 1+n*(d+2)) predicts every observation.
`timescale 1ns/1ps
module tb_renkon_layer_sched;
    localparam int LWIDTH = 10, MEMSIZE = 12, NETSIZE = 11, MAXLAYER = 8, CWIDTH = 16;

    typedef struct packed {
        logic [9:0]  qbits, total_out, total_in, img_height, img_width;
        logic [9:0]  fea_height, fea_width, conv_kern, conv_strid, conv_pad;
        logic [9:0]  pool_kern, pool_strid, pool_pad;
        logic        bias_en, relu_en, pool_en;
        logic [11:0] in_offset, out_offset;
        logic [10:0] net_offset;
    } desc_t;

    logic clk = 1'b0;
    logic rst;
    renkon_layer_sched_if #(.LWIDTH(LWIDTH), .MEMSIZE(MEMSIZE), .NETSIZE(NETSIZE),
                            .MAXLAYER(MAXLAYER), .CWIDTH(CWIDTH)) bus ();

    renkon_layer_sched #(.LWIDTH(LWIDTH), .MEMSIZE(MEMSIZE), .NETSIZE(NETSIZE),
                         .MAXLAYER(MAXLAYER), .CWIDTH(CWIDTH)) dut (
        .clk (clk),
        .xrst(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    desc_t model [MAXLAYER];

    desc_t obs_desc [$];
    int    obs_cyc  [$];
    int    obs_idx  [$];
    int    done_cyc;
    int    done_cnt;
    int    busy_cycles;
    logic [31:0] cnt_at_done;
    logic  abort_zero;

    function automatic desc_t snap();
        desc_t d;
        d.qbits = bus.qbits;           d.total_out = bus.total_out;   d.total_in = bus.total_in;
        d.img_height = bus.img_height; d.img_width = bus.img_width;   d.fea_height = bus.fea_height;
        d.fea_width = bus.fea_width;   d.conv_kern = bus.conv_kern;   d.conv_strid = bus.conv_strid;
        d.conv_pad = bus.conv_pad;     d.pool_kern = bus.pool_kern;   d.pool_strid = bus.pool_strid;
        d.pool_pad = bus.pool_pad;     d.bias_en = bus.bias_en;       d.relu_en = bus.relu_en;
        d.pool_en = bus.pool_en;       d.in_offset = bus.in_offset;   d.out_offset = bus.out_offset;
        d.net_offset = bus.net_offset;
        return d;
    endfunction

    function automatic void model_write(input int l, input int f, input logic [15:0] v);
        case (f)
            0:  model[l].qbits      = v[9:0];
            1:  model[l].total_out  = v[9:0];
            2:  model[l].total_in   = v[9:0];
            3:  model[l].img_height = v[9:0];
            4:  model[l].img_width  = v[9:0];
            5:  model[l].fea_height = v[9:0];
            6:  model[l].fea_width  = v[9:0];
            7:  model[l].conv_kern  = v[9:0];
            8:  model[l].conv_strid = v[9:0];
            9:  model[l].conv_pad   = v[9:0];
            10: model[l].pool_kern  = v[9:0];
            11: model[l].pool_strid = v[9:0];
            12: model[l].pool_pad   = v[9:0];
            13: begin model[l].bias_en = v[0]; model[l].relu_en = v[1]; model[l].pool_en = v[2]; end
            14: model[l].in_offset  = v[11:0];
            15: model[l].out_offset = v[11:0];
            16: model[l].net_offset = v[10:0];
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int l, input int f, input logic [15:0] v);
        bus.cfg_we = 1'b1; bus.cfg_layer = 3'(l); bus.cfg_field = 5'(f); bus.cfg_wdata = v;
        tick();
        bus.cfg_we = 1'b0;
        model_write(l, f, v);
    endtask

    // Drives one run and records what the DUT shows; -1 disables an optional event.
    task automatic run(input int nl, input int dly, input int again_at, input int we_at, input int rst_at);
        int ack_at = -1;
        obs_desc.delete(); obs_cyc.delete(); obs_idx.delete();
        done_cyc = -1; done_cnt = 0; busy_cycles = 0; abort_zero = 1'b0;
        bus.start = 1'b1; bus.num_layers = 4'(nl);
        tick();
        for (int c = 1; c < 400; c++) begin
            bus.ack = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                abort_zero = !bus.req && !bus.busy && !bus.done && (bus.layer_idx == 3'd0) &&
                             (bus.cycle_cnt == 32'd0) && (snap() == '0) && !bus.cfg_err && !bus.proto_err;
                #2;
                rst = 1'b0;
                tick();
                return;
            end
            if (bus.busy) busy_cycles++;
            if (bus.req) begin
                obs_desc.push_back(snap()); obs_cyc.push_back(c); obs_idx.push_back(int'(bus.layer_idx));
                ack_at = c + dly;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; cnt_at_done = bus.cycle_cnt; end
            end
            if (c == ack_at) bus.ack = 1'b1;
            if (c == again_at) begin bus.start = 1'b1; bus.num_layers = 4'd1; end
            if (c == we_at) begin
                bus.cfg_we = 1'b1; bus.cfg_layer = 3'd0; bus.cfg_field = 5'd0; bus.cfg_wdata = 16'($urandom);
            end
            if ((done_cyc >= 0) && (c >= done_cyc + 3)) break;
            tick();
        end
        bus.ack = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (snap() !== '0) $display("[TB] FAIL reset_fields got %h want 0", snap()); else passed++;
        checks++;
        if ({bus.req, bus.busy, bus.done, bus.cfg_err, bus.proto_err} !== 5'b0 || bus.cycle_cnt !== 32'd0 || bus.layer_idx !== 3'd0)
            $display("[TB] FAIL reset_ctrl got req=%b busy=%b done=%b cnt=%0d idx=%0d want all 0",
                     bus.req, bus.busy, bus.done, bus.cycle_cnt, bus.layer_idx);
        else passed++;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic load_table();
        for (int l = 0; l < MAXLAYER; l++)
            for (int f = 0; f < 17; f++) cfg_write(l, f, 16'($urandom));
        for (int f = 17; f < 32; f++) cfg_write(int'($urandom_range(0, 7)), f, 16'($urandom));
    endtask

    // Shared expectations for a completed run of nl requested layers with ack delay d.
    task automatic expect_run(input string tag, input int nl, input int d);
        int n = (nl > MAXLAYER) ? MAXLAYER : nl;
        checks++; if (obs_cyc.size() !== n) $display("[TB] FAIL %s_req_count got %0d want %0d", tag, obs_cyc.size(), n); else passed++;
        for (int i = 0; i < n && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== 2 + i * (d + 2)) $display("[TB] FAIL %s_req_cycle[%0d] got %0d want %0d", tag, i, obs_cyc[i], 2 + i * (d + 2)); else passed++;
            checks++; if (obs_idx[i] !== i) $display("[TB] FAIL %s_layer_idx[%0d] got %0d want %0d", tag, i, obs_idx[i], i); else passed++;
            checks++; if (obs_desc[i] !== model[i]) $display("[TB] FAIL %s_fields[%0d] got %h want %h", tag, i, obs_desc[i], model[i]); else passed++;
        end
        checks++; if (done_cyc !== 1 + n * (d + 2)) $display("[TB] FAIL %s_done_cycle got %0d want %0d", tag, done_cyc, 1 + n * (d + 2)); else passed++;
        checks++; if (cnt_at_done !== 32'(n * (d + 2))) $display("[TB] FAIL %s_cycle_cnt got %0d want %0d", tag, cnt_at_done, n * (d + 2)); else passed++;
        checks++; if (done_cnt !== 1) $display("[TB] FAIL %s_done_pulses got %0d want 1", tag, done_cnt); else passed++;
        checks++; if (busy_cycles !== n * (d + 2)) $display("[TB] FAIL %s_busy_cycles got %0d want %0d", tag, busy_cycles, n * (d + 2)); else passed++;
    endtask

    task automatic test_single_layer();
        cfg_write(0, 0, 16'd8); cfg_write(0, 7, 16'd3); cfg_write(0, 13, 16'b101); cfg_write(0, 14, 16'h0100);
        run(1, 10, -1, -1, -1);
        expect_run("single", 1, 10);
        checks++;
        if (obs_desc.size() < 1 || obs_desc[0].qbits !== 10'd8 || obs_desc[0].in_offset !== 12'h100 ||
            {obs_desc[0].bias_en, obs_desc[0].relu_en, obs_desc[0].pool_en} !== 3'b101)
            $display("[TB] FAIL single_literal_fields got %h want qbits=8 in_offset=100 flags=101", (obs_desc.size() > 0) ? obs_desc[0] : '0);
        else passed++;
        checks++; if (bus.proto_err !== 1'b0) $display("[TB] FAIL single_proto_err got %b want 0", bus.proto_err); else passed++;
    endtask

    task automatic test_multi_layer();
        cfg_write(0, 15, 16'h10); cfg_write(1, 15, 16'h20); cfg_write(2, 15, 16'h30);
        run(3, 5, -1, -1, -1);
        expect_run("multi", 3, 5);
    endtask

    task automatic test_write_with_start();
        logic [15:0] v = 16'($urandom);
        bus.cfg_we = 1'b1; bus.cfg_layer = 3'd0; bus.cfg_field = 5'd15; bus.cfg_wdata = v;
        model_write(0, 15, v);
        run(1, 3, -1, -1, -1);
        expect_run("we_start", 1, 3);
    endtask

    task automatic test_zero_layers();
        run(0, 4, -1, -1, -1);
        expect_run("zero", 0, 4);
    endtask

    task automatic test_cfg_while_busy();
        run(1, 6, -1, 5, -1);
        checks++; if (bus.cfg_err !== 1'b1) $display("[TB] FAIL cfg_err_set got %b want 1", bus.cfg_err); else passed++;
        run(1, 6, -1, -1, -1);
        expect_run("cfg_rerun", 1, 6);
        checks++; if (bus.cfg_err !== 1'b0) $display("[TB] FAIL cfg_err_clear got %b want 0", bus.cfg_err); else passed++;
    endtask

    task automatic test_proto();
        run(2, 4, 4, -1, -1);
        expect_run("restart_ignored", 2, 4);
        checks++; if (bus.proto_err !== 1'b0) $display("[TB] FAIL proto_before got %b want 0", bus.proto_err); else passed++;
        bus.ack = 1'b1; tick(); bus.ack = 1'b0; tick();
        checks++; if (bus.proto_err !== 1'b1) $display("[TB] FAIL proto_idle_ack got %b want 1", bus.proto_err); else passed++;
        checks++; if ({bus.busy, bus.req} !== 2'b00) $display("[TB] FAIL proto_idle_quiet got busy=%b req=%b want 0 0", bus.busy, bus.req); else passed++;
    endtask

    task automatic test_reset_midrun();
        run(3, 5, -1, -1, 11);
        checks++; if (abort_zero !== 1'b1) $display("[TB] FAIL midrun_outputs_zero got %b want 1", abort_zero); else passed++;
        checks++; if (obs_cyc.size() !== 2) $display("[TB] FAIL midrun_reqs_before got %0d want 2", obs_cyc.size()); else passed++;
        run(3, 5, -1, -1, -1);
        expect_run("after_reset", 3, 5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int nl = int'($urandom_range(0, 15));
            int d  = int'($urandom_range(1, 8));
            for (int w = 0; w < 6; w++)
                cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 20)), 16'($urandom));
            run(nl, d, -1, -1, -1);
            expect_run($sformatf("rand%0d", k), nl, d);
        end
    endtask

    task automatic test_hold();
        run(4, 2, -1, -1, -1);
        expect_run("hold_run", 4, 2);
        repeat (5) tick();
        checks++; if (snap() !== model[3]) $display("[TB] FAIL hold_fields got %h want %h", snap(), model[3]); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd16) $display("[TB] FAIL hold_cycle_cnt got %0d want 16", bus.cycle_cnt); else passed++;
    endtask

    initial begin
        bus.start = 1'b0; bus.num_layers = '0; bus.cfg_we = 1'b0; bus.cfg_layer = '0;
        bus.cfg_field = '0; bus.cfg_wdata = '0; bus.ack = 1'b0;
        test_reset();
        load_table();
        test_single_layer();
        test_multi_layer();
        test_write_with_start();
        test_zero_layers();
        test_cfg_while_busy();
        test_proto();
        test_reset_midrun();
        test_random();
        test_hold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
